seq_mod_checker: RTL and testbench

Parametrised streaming divisibility checker. Accepts a number as a stream of digits in base `RADIX`, most significant digit first, and keeps a running remainder modulo `DIVISOR`. At the end of each frame it presents a registered result: divisible flag, remainder, digit count and an invalid-digit error. It is the generalised successor of the fixed BCD divide-by-3 checker, adding arbitrary radix and divisor, framing, valid/ready handshakes on both sides and error detection.

---
 rtl/seq_mod_pkg.sv | 27 ++
 rtl/mod_step.sv | 39 +++
 rtl/seq_mod_checker.sv | 153 +++++++++++++++
 tb/tb_seq_mod_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mod_pkg.sv
// Shared types and width helpers for the streaming divisibility checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_mod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time width derivation; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Remainder width: enough bits for 0..divisor-1, never narrower than one bit.
  function automatic int rem_width(input int divisor);
    return (clog2(divisor) < 1) ? 1 : clog2(divisor);
  endfunction

endpackage

// File: rtl/mod_step.sv
// One Horner step of a radix-RADIX number modulo DIVISOR, plus invalid-digit flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
//
// Ports:
//   rem_in    running remainder before this digit (must be < DIVISOR)
//   digit     incoming digit, MSD-first order
//   rem_out   (rem_in * RADIX + digit') mod DIVISOR
//   digit_bad digit >= RADIX; such a digit contributes 0 to the remainder
module mod_step
  import seq_mod_pkg::*;
#(
  parameter int RADIX   = 10,
  parameter int DIVISOR = 3,
  parameter int DIGIT_W = 4,
  parameter int REM_W   = 2
) (
  input  logic [REM_W-1:0]   rem_in,
  input  logic [DIGIT_W-1:0] digit,
  output logic [REM_W-1:0]   rem_out,
  output logic               digit_bad
);

  // Wide enough that rem_in * RADIX + digit can never overflow.
  localparam int WIDE_W = REM_W + DIGIT_W + clog2(RADIX) + 1;
  localparam logic [WIDE_W-1:0] RADIX_W   = WIDE_W'(RADIX);
  localparam logic [WIDE_W-1:0] DIVISOR_W = WIDE_W'(DIVISOR);

  logic [WIDE_W-1:0] digit_eff;
  logic [WIDE_W-1:0] wide;

  always_comb begin
    digit_bad = (WIDE_W'(digit) >= RADIX_W);
    digit_eff = digit_bad ? '0 : WIDE_W'(digit);
    wide      = (WIDE_W'(rem_in) * RADIX_W) + digit_eff;
    rem_out   = REM_W'(wide % DIVISOR_W);
  end

endmodule

// File: rtl/seq_mod_checker.sv
// Streaming divisibility checker: MSD-first digits in, per-frame remainder/flags out.
// Latency: result valid the cycle after the in_last digit is accepted; 1 digit/cycle.
// Backpressure: in_ready drops while a result is held; result held until out_ready.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   in_valid/in_ready          digit handshake; in_digit, in_last qualify with it
//   out_valid/out_ready        result handshake
//   out_divisible              remainder is 0 and no invalid digit was seen
//   out_remainder              number mod DIVISOR
//   out_count                  digits in frame, saturating at 2^CNT_W-1
//   out_error                  at least one digit was >= RADIX
module seq_mod_checker
  import seq_mod_pkg::*;
#(
  parameter  int RADIX   = 10,
  parameter  int DIGIT_W = 4,
  parameter  int DIVISOR = 3,
  parameter  int CNT_W   = 8,
  localparam int REM_W   = rem_width(DIVISOR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIGIT_W-1:0] in_digit,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_divisible,
  output logic [REM_W-1:0]   out_remainder,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_error
);

  state_t             state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               out_valid_q, out_valid_d;
  logic               res_div_q, res_div_d;
  logic [REM_W-1:0]   res_rem_q, res_rem_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic               res_err_q, res_err_d;

  logic               accept;
  logic [REM_W-1:0]   step_rem_in;
  logic [REM_W-1:0]   step_rem;
  logic               digit_bad;
  logic [CNT_W-1:0]   cnt_inc;

  // A new frame starts from remainder 0, so the stale rem_q is masked in IDLE.
  assign step_rem_in = (state_q == ST_IDLE) ? '0 : rem_q;

  mod_step #(
    .RADIX   (RADIX),
    .DIVISOR (DIVISOR),
    .DIGIT_W (DIGIT_W),
    .REM_W   (REM_W)
  ) u_mod_step (
    .rem_in    (step_rem_in),
    .digit     (in_digit),
    .rem_out   (step_rem),
    .digit_bad (digit_bad)
  );

  // in_ready depends only on the state register, never on out_ready.
  assign in_ready = (state_q != ST_DONE);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    res_div_d   = res_div_q;
    res_rem_d   = res_rem_q;
    res_cnt_d   = res_cnt_q;
    res_err_d   = res_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rem_d   = step_rem;
          cnt_d   = CNT_W'(1);
          err_d   = digit_bad;
          state_d = in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          rem_d = step_rem;
          cnt_d = cnt_inc;
          err_d = err_q | digit_bad;
          if (in_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Result registers capture the next-state values on entry to DONE, so the
    // final digit is already folded in.
    if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
      out_valid_d = 1'b1;
      res_rem_d   = rem_d;
      res_cnt_d   = cnt_d;
      res_err_d   = err_d;
      res_div_d   = (rem_d == '0) && !err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      res_div_q   <= 1'b0;
      res_rem_q   <= '0;
      res_cnt_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      res_div_q   <= res_div_d;
      res_rem_q   <= res_rem_d;
      res_cnt_q   <= res_cnt_d;
      res_err_q   <= res_err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_divisible = res_div_q;
  assign out_remainder = res_rem_q;
  assign out_count     = res_cnt_q;
  assign out_error     = res_err_q;

endmodule

// File: tb/tb_seq_mod_checker.sv
// Self-checking bench: three checker instances (defaults, DIVISOR=7, CNT_W=2) share stimulus.
// Latency: expected results queued when the in_last digit is accepted.
// Backpressure: monitor compares every held result cycle and pops on out_ready.
module tb_seq_mod_checker;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid;
  logic [3:0] in_digit;
  logic       in_last;
  logic       out_ready;

  // u0: defaults, u1: DIVISOR=7, u2: CNT_W=2
  logic       rdy0, rdy1, rdy2;
  logic       vld0, vld1, vld2;
  logic       div0, div1, div2;
  logic [1:0] rem0;
  logic [2:0] rem1;
  logic [1:0] rem2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic       err0, err1, err2;

  seq_mod_checker u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_digit(in_digit), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
    .out_divisible(div0), .out_remainder(rem0), .out_count(cnt0), .out_error(err0)
  );

  seq_mod_checker #(.DIVISOR(7)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_digit(in_digit), .in_last(in_last), .out_valid(vld1), .out_ready(out_ready),
    .out_divisible(div1), .out_remainder(rem1), .out_count(cnt1), .out_error(err1)
  );

  seq_mod_checker #(.CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
    .in_digit(in_digit), .in_last(in_last), .out_valid(vld2), .out_ready(out_ready),
    .out_divisible(div2), .out_remainder(rem2), .out_count(cnt2), .out_error(err2)
  );

  typedef struct {
    bit div;
    int rem;
    int cnt;
    bit err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   digs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: Horner evaluation in base 10, invalid digits count as 0.
  function automatic exp_t model(input int divisor, input int cnt_w);
    exp_t e;
    int   r, c, dd;
    bit   er;
    r = 0; c = 0; er = 0;
    foreach (digs[i]) begin
      dd = (digs[i] < 10) ? digs[i] : 0;
      if (digs[i] >= 10) er = 1;
      r = (r * 10 + dd) % divisor;
      if (c < (1 << cnt_w) - 1) c++;
    end
    e.div = (r == 0) && !er;
    e.rem = r;
    e.cnt = c;
    e.err = er;
    return e;
  endfunction

  // Entry and exit at posedge+#1.
  task automatic send_digit(input int d, input bit last);
    bit got;
    got = 0;
    in_valid = 1'b1;
    in_digit = d[3:0];
    in_last  = last;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rdy0) got = 1;
      @(posedge clk);
      #1;
    end
    if (!got) check("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (got) begin
      digs.push_back(d);
      if (last) begin
        q0.push_back(model(3, 8));
        q1.push_back(model(7, 8));
        q2.push_back(model(3, 2));
        digs.delete();
        @(negedge clk);
        check("latency_u0", {31'd0, vld0}, 32'd1);
        check("latency_u1", {31'd0, vld1}, 32'd1);
        check("latency_u2", {31'd0, vld2}, 32'd1);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon(input int k, input logic vld, input logic dv, input int rm,
                     input int ct, input logic er);
    exp_t e;
    int   sz;
    if (!vld) return;
    sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      check($sformatf("u%0d_spurious_valid", k), {31'd0, vld}, 32'd0);
      return;
    end
    e = (k == 0) ? q0[0] : (k == 1) ? q1[0] : q2[0];
    check($sformatf("u%0d_remainder", k), rm, e.rem);
    check($sformatf("u%0d_count", k), ct, e.cnt);
    check($sformatf("u%0d_error", k), {31'd0, er}, {31'd0, e.err});
    check($sformatf("u%0d_divisible", k), {31'd0, dv}, {31'd0, e.div});
    if (out_ready) begin
      if (k == 0) void'(q0.pop_front());
      else if (k == 1) void'(q1.pop_front());
      else void'(q2.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, vld0, div0, int'(rem0), int'(cnt0), err0);
      mon(1, vld1, div1, int'(rem1), int'(cnt1), err1);
      mon(2, vld2, div2, int'(rem2), int'(cnt2), err2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_digit  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(3);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", {29'd0, rdy0, rdy1, rdy2}, 32'h7);
    check("rst_out_valid", {29'd0, vld0, vld1, vld2}, 32'h0);
    check("rst_remainder", {27'd0, rem0, rem1}, 32'd0);
    check("rst_count", {16'd0, cnt0, cnt1}, 32'd0);
    check("rst_flags", {28'd0, div0, div1, err0, err1}, 32'd0);
    @(posedge clk);
    #1;

    // 123 and 124
    send_digit(1, 0); send_digit(2, 0); send_digit(3, 1);
    send_digit(1, 0); send_digit(2, 0); send_digit(4, 1);
    // 91 and 100 (DIVISOR=7 instance: remainders 0 and 2)
    send_digit(9, 0); send_digit(1, 1);
    send_digit(1, 0); send_digit(0, 0); send_digit(0, 1);
    // invalid middle digit
    send_digit(1, 0); send_digit(12, 0); send_digit(3, 1);
    // single-digit frame with invalid digit
    send_digit(15, 1);

    // Backpressure: hold result, offered digit must be ignored
    out_ready = 1'b0;
    send_digit(4, 0); send_digit(5, 1);
    in_valid = 1'b1;
    in_digit = 4'd7;
    in_last  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", {29'd0, rdy0, rdy1, rdy2}, 32'h0);
      check("bp_out_valid", {29'd0, vld0, vld1, vld2}, 32'h7);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_released", {29'd0, vld0, vld1, vld2}, 32'h0);
    @(posedge clk);
    #1;
    send_digit(1, 0); send_digit(2, 0); send_digit(3, 1);

    // Reset mid-frame discards the partial number
    send_digit(2, 0); send_digit(2, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    digs.delete();
    send_digit(3, 1);

    // Count saturation on the CNT_W=2 instance
    send_digit(1, 0); send_digit(2, 0); send_digit(3, 0); send_digit(4, 0); send_digit(5, 1);

    // Random frames, back to back
    for (int f = 0; f < 4; f++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) send_digit(int'($urandom_range(0, 15)), i == len - 1);
    end

    idle(4);
    check("drain_u0", q0.size(), 32'd0);
    check("drain_u1", q1.size(), 32'd0);
    check("drain_u2", q2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
